// File: rtl/wta_pkg.sv
// Shared types and width helpers for the temporal winner-take-all stage.
package wta_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } wta_state_t;

  function automatic int unsigned idx_w(input int unsigned width);
    return (width > 1) ? int'($clog2(width)) : 1;
  endfunction

  function automatic int unsigned time_w(input int unsigned gamma_cycle_width);
    return (gamma_cycle_width > 1) ? int'($clog2(gamma_cycle_width)) : 1;
  endfunction

endpackage

// File: rtl/temporal_wta_if.sv
// Race-logic bundle between mem_group_share, the WTA stage and the readout.
interface temporal_wta_if
  import wta_pkg::*;
#(
  parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
  parameter int unsigned WIDTH             = 8
);
  localparam int unsigned IDX_W  = idx_w(WIDTH);
  localparam int unsigned TIME_W = time_w(GAMMA_CYCLE_WIDTH);

  logic [WIDTH-1:0]  in;
  logic [WIDTH-1:0]  out;
  logic [IDX_W-1:0]  winner_idx;
  logic [TIME_W-1:0] winner_time;
  logic              winner_valid;

  // master: upstream driver / downstream consumer side
  modport master (output in, input out, winner_idx, winner_time, winner_valid);
  // slave: the WTA stage itself
  modport slave  (input in, output out, winner_idx, winner_time, winner_valid);

endinterface

// File: rtl/wta_priority_pick.sv
// Combinational picker: first set request at or above ptr, wrapping modulo WIDTH.
module wta_priority_pick
  import wta_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  int unsigned j;

  always_comb begin
    idx_c = '0;
    any_c = 1'b0;
    j     = 0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      j = (32'(ptr) + i) % WIDTH;
      if (!any_c && req[j]) begin
        any_c = 1'b1;
        idx_c = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/temporal_wta.sv
// Temporal winner-take-all: first rising line per gamma cycle wins, later rises inhibited.
// Optional WTA_TIE_ROUND_ROBIN_EN: ties resolved round-robin instead of lowest index.
module temporal_wta
  import wta_pkg::*;
#(
  parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
  parameter int unsigned WIDTH             = 8
) (
  input  logic           aclk,
  input  logic           rst,
  input  logic           grst,
  temporal_wta_if.slave  bus
);

  localparam int unsigned IDX_W  = idx_w(WIDTH);
  localparam int unsigned TIME_W = time_w(GAMMA_CYCLE_WIDTH);
  localparam logic [TIME_W-1:0] TCNT_MAX = TIME_W'(GAMMA_CYCLE_WIDTH - 1);

  wta_state_t        state_q, state_d;
  logic [TIME_W-1:0] tcnt_q, tcnt_d;
  logic [WIDTH-1:0]  in_q, in_q_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic              valid_q, valid_d;

  logic [WIDTH-1:0]  rise_c;
  logic [IDX_W-1:0]  pick_idx_c;
  logic              pick_any_c;
  logic [IDX_W-1:0]  pick_ptr_c;

`ifdef WTA_TIE_ROUND_ROBIN_EN
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

  assign pick_ptr_c = rr_ptr_q;
  assign rr_ptr_d   = (state_q == ARMED && !grst && pick_any_c)
                    ? ((pick_idx_c == IDX_W'(WIDTH - 1)) ? '0 : pick_idx_c + IDX_W'(1))
                    : rr_ptr_q;

  // Pointer survives grst so fairness spans gamma cycles.
  always_ff @(posedge aclk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`else
  assign pick_ptr_c = '0;
`endif

  assign rise_c = (state_q == ARMED) ? (bus.in & ~in_q) : '0;

  wta_priority_pick #(.WIDTH(WIDTH)) u_pick (
    .req   (rise_c),
    .ptr   (pick_ptr_c),
    .idx_c (pick_idx_c),
    .any_c (pick_any_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    in_q_d  = bus.in;
    out_d   = out_q;
    idx_d   = idx_q;
    time_d  = time_q;
    valid_d = valid_q;
    if (grst) begin
      state_d = ARMED;
      tcnt_d  = '0;
      in_q_d  = '0;
      out_d   = '0;
      valid_d = 1'b0;
    end else begin
      if (tcnt_q != TCNT_MAX) tcnt_d = tcnt_q + TIME_W'(1);
      if (state_q == ARMED && pick_any_c) begin
        state_d = LOCKED;
        out_d   = WIDTH'(1) << pick_idx_c;
        idx_d   = pick_idx_c;
        time_d  = tcnt_q;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      in_q    <= '0;
      out_q   <= '0;
      idx_q   <= '0;
      time_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      in_q    <= in_q_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      time_q  <= time_d;
      valid_q <= valid_d;
    end
  end

  assign bus.out          = out_q;
  assign bus.winner_idx   = idx_q;
  assign bus.winner_time  = time_q;
  assign bus.winner_valid = valid_q;

endmodule

// File: tb/tb_temporal_wta.sv
// Directed bench for temporal_wta; tie expectations follow WTA_TIE_ROUND_ROBIN_EN.
module tb_temporal_wta;

  logic aclk = 1'b0;
  logic rst;
  logic grst;
  int   checks = 0;
  int   errors = 0;
  logic [2:0] rr = 3'd0;

  always #5 aclk = ~aclk;

  temporal_wta_if #(.GAMMA_CYCLE_WIDTH(16), .WIDTH(8)) intf ();

  temporal_wta #(.GAMMA_CYCLE_WIDTH(16), .WIDTH(8)) dut (
    .aclk (aclk),
    .rst  (rst),
    .grst (grst),
    .bus  (intf.slave)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_win(input string tag, input logic [2:0] idx, input logic [3:0] tm);
    logic [7:0] oh;
    oh = 8'd1 << idx;
    chk({tag, "_out"},   32'(intf.out), 32'(oh));
    chk({tag, "_idx"},   32'(intf.winner_idx), 32'(idx));
    chk({tag, "_time"},  32'(intf.winner_time), 32'(tm));
    chk({tag, "_valid"}, 32'(intf.winner_valid), 32'd1);
  endtask

  task automatic chk_none(input string tag);
    chk({tag, "_out"},   32'(intf.out), 32'd0);
    chk({tag, "_valid"}, 32'(intf.winner_valid), 32'd0);
  endtask

  function automatic logic [2:0] exp_pick(input logic [7:0] req, input logic [2:0] p);
    for (int i = 0; i < 8; i++) begin
      int k;
      k = (int'(p) + i) % 8;
      if (req[k]) return 3'(k);
    end
    return 3'd0;
  endfunction

  task automatic note_capture(input logic [2:0] idx);
`ifdef WTA_TIE_ROUND_ROBIN_EN
    rr = idx + 3'd1;
`else
    rr = 3'd0 & idx;
`endif
  endtask

  task automatic gamma_start();
    grst = 1'b1;
    step();
    grst = 1'b0;
  endtask

  initial begin
    logic [2:0] e;
    rst = 1'b1; grst = 1'b0; intf.in = '0;
    step(2);
    chk("reset_out",   32'(intf.out), 32'd0);
    chk("reset_idx",   32'(intf.winner_idx), 32'd0);
    chk("reset_time",  32'(intf.winner_time), 32'd0);
    chk("reset_valid", 32'(intf.winner_valid), 32'd0);
    rst = 1'b0;

    // IDLE ignores rises
    intf.in = 8'h01;
    step(3);
    chk_none("idle");
    intf.in = '0;
    step();

    // G1: in[5] rises at t=3
    gamma_start();
    step(3);
    chk_none("g1_t3");
    intf.in = 8'h20;
    step();
    chk_win("g1_t4", 3'd5, 4'd3);
    note_capture(3'd5);
    intf.in = 8'h21;
    step(4);
    chk_win("g1_hold", 3'd5, 4'd3);
    intf.in = '0;
    gamma_start();
    chk_none("g1_grst");
    chk("g1_grst_idx",  32'(intf.winner_idx), 32'd5);
    chk("g1_grst_time", 32'(intf.winner_time), 32'd3);

    // G2: tie between in[2] and in[6] at t=2
    step(2);
    intf.in = 8'h44;
    step();
    e = exp_pick(8'h44, rr);
`ifndef WTA_TIE_ROUND_ROBIN_EN
    chk("g2_default_lowest", 32'(e), 32'd2);
`endif
    chk_win("g2_tie", e, 4'd2);
    note_capture(e);

    // G3: winner in[1] at t=1, later rises ignored
    intf.in = '0;
    gamma_start();
    step(1);
    intf.in = 8'h02;
    step();
    e = exp_pick(8'h02, rr);
    chk_win("g3_t2", e, 4'd1);
    note_capture(e);
    step(4);
    intf.in = 8'h03;
    step(3);
    intf.in = 8'h83;
    step();
    chk_win("g3_t10", 3'd1, 4'd1);

    // G4: no spike for a full gamma cycle, then a late spike shows tcnt saturation
    intf.in = '0;
    gamma_start();
    for (int c = 0; c < 16; c++) begin
      chk_none("g4_quiet");
      step();
    end
    step(8);
    chk_none("g4_late");
    intf.in = 8'h08;
    step();
    chk_win("g4_sat", exp_pick(8'h08, rr), 4'd15);
    note_capture(3'd3);

    // G5: rst mid-operation after a winner at t=2
    intf.in = '0;
    gamma_start();
    step(2);
    intf.in = 8'h04;
    step();
    chk_win("g5_t3", exp_pick(8'h04, rr), 4'd2);
    step(2);
    rst = 1'b1;
    intf.in = '0;
    step();
    rst = 1'b0;
    rr = 3'd0;
    chk("g5_rst_out",   32'(intf.out), 32'd0);
    chk("g5_rst_idx",   32'(intf.winner_idx), 32'd0);
    chk("g5_rst_time",  32'(intf.winner_time), 32'd0);
    chk("g5_rst_valid", 32'(intf.winner_valid), 32'd0);
    step(1);
    intf.in = 8'h08;
    step(3);
    chk_none("g5_idle_ignore");
    gamma_start();
    step();
    chk_win("g5_rearm", 3'd3, 4'd0);
    note_capture(3'd3);

    // G6: rise coincident with grst is discarded, then seen at t=0
    intf.in = '0;
    step();
    intf.in = 8'h10;
    gamma_start();
    chk_none("g6_grst");
    step();
    chk_win("g6_t0", 3'd4, 4'd0);

    // rst wins over grst
    intf.in = '0;
    rst = 1'b1; grst = 1'b1;
    step();
    rst = 1'b0; grst = 1'b0;
    intf.in = 8'h01;
    step(3);
    chk_none("rst_over_grst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
